// File: rtl/tb_mem_latency_model.sv
// tb_mem_latency_model: banked testbench memory with byte strobes, fixed read latency and optional grant stalls
// Sits on the mem_* side of axi_to_mem in place of a 1-cycle SRAM slave.
// Ports (per bank b, packed little-end first):
//   clk_i, rst_ni                clock, asynchronous active-low reset
//   mem_req_i / mem_gnt_o        request / grant; accepted when req & gnt
//   mem_addr_i                   byte address, AddrWidth bits per bank
//   mem_wdata_i / mem_strb_i     write data and byte enables
//   mem_we_i                     1 = write, 0 = read
//   mem_rvalid_o / mem_rdata_o   one response per accept, ReadLatency cycles later; rdata 0 for writes
// Build option: define TB_MEM_STALL_EN to withhold the grant one cycle in every StallPeriod.
module tb_mem_latency_model #(
  parameter int unsigned NumBanks    = 1,
  parameter int unsigned NumWords    = 256,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned AddrWidth   = 9,
  parameter int unsigned ReadLatency = 1,
  parameter int unsigned StallPeriod = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumBanks-1:0]             mem_req_i,
  output logic [NumBanks-1:0]             mem_gnt_o,
  input  logic [NumBanks*AddrWidth-1:0]   mem_addr_i,
  input  logic [NumBanks*DataWidth-1:0]   mem_wdata_i,
  input  logic [NumBanks*DataWidth/8-1:0] mem_strb_i,
  input  logic [NumBanks-1:0]             mem_we_i,
  output logic [NumBanks-1:0]             mem_rvalid_o,
  output logic [NumBanks*DataWidth-1:0]   mem_rdata_o
);
  localparam int unsigned BW = DataWidth / 8;
  localparam int unsigned OW = $clog2(BW);
  localparam int unsigned IW = $clog2(NumWords);
  if (NumWords < 2 || (NumWords & (NumWords - 1)) != 0) begin : g_bad_words
    $error("NumWords must be a power of 2 and at least 2");
  end
  if (ReadLatency < 1 || ReadLatency > 16) begin : g_bad_latency
    $error("ReadLatency must be in 1..16");
  end
  if (StallPeriod == 1) begin : g_bad_stall
    $error("StallPeriod of 1 would never grant");
  end
  if (DataWidth % 8 != 0) begin : g_bad_width
    $error("DataWidth must be a multiple of 8");
  end
  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    logic [DataWidth-1:0] mem [NumWords];
    logic [DataWidth-1:0] pd [ReadLatency];
    logic [ReadLatency-1:0] pv;
    logic [DataWidth-1:0] wd, merged;
    logic [BW-1:0] st;
    logic [IW-1:0] idx;
    logic stall, acc, we;
    // byte-offset bits dropped, upper bits wrap onto the array
    assign idx = IW'(mem_addr_i[b*AddrWidth +: AddrWidth] >> OW);
    assign wd = mem_wdata_i[b*DataWidth +: DataWidth];
    assign st = mem_strb_i[b*BW +: BW];
    assign we = mem_we_i[b];
`ifdef TB_MEM_STALL_EN
    if (StallPeriod > 1) begin : g_stall
      localparam int unsigned CW = $clog2(StallPeriod);
      logic [CW-1:0] cnt;
      always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cnt <= '0;
        else cnt <= (cnt == CW'(StallPeriod - 1)) ? '0 : cnt + CW'(1);
      assign stall = cnt == CW'(StallPeriod - 1);
    end else begin : g_no_stall
      assign stall = 1'b0;
    end
`else
    assign stall = 1'b0;
`endif
    // grant is held low throughout reset so nothing is accepted then
    assign mem_gnt_o[b] = rst_ni & mem_req_i[b] & ~stall;
    assign acc = mem_gnt_o[b];
    always_comb begin
      merged = mem[idx];
      for (int j = 0; j < BW; j++) merged[j*8 +: 8] = st[j] ? wd[j*8 +: 8] : merged[j*8 +: 8];
    end
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) for (int i = 0; i < NumWords; i++) mem[i] <= '0;
      else if (acc && we) mem[idx] <= merged;
    // reads sample the pre-write word since the array updates non-blocking
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
        pv <= '0;
        for (int i = 0; i < ReadLatency; i++) pd[i] <= '0;
      end else begin
        pv[0] <= acc;
        pd[0] <= (acc && !we) ? mem[idx] : '0;
        for (int i = 1; i < ReadLatency; i++) begin
          pv[i] <= pv[i-1];
          pd[i] <= pd[i-1];
        end
      end
    assign mem_rvalid_o[b] = pv[ReadLatency-1];
    assign mem_rdata_o[b*DataWidth +: DataWidth] = pv[ReadLatency-1] ? pd[ReadLatency-1] : '0;
  end
endmodule

// File: tb/tb_tb_mem_latency_model.sv
// tb_tb_mem_latency_model: randomized and directed checks of tb_mem_latency_model against a queue-based model
module tb_tb_mem_latency_model;
  localparam int NB = 2;
  localparam int NW = 256;
  localparam int DW = 64;
  localparam int AW = 12;
  localparam int RL = 3;
  localparam int SP = 4;
  localparam int SW = DW / 8;
`ifdef TB_MEM_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [NB-1:0] req = '0;
  logic [NB-1:0] we = '0;
  logic [NB*AW-1:0] addr = '0;
  logic [NB*DW-1:0] wdata = '0;
  logic [NB*SW-1:0] strb = '0;
  logic [NB-1:0] gnt, rvalid;
  logic [NB*DW-1:0] rdata;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  typedef struct {int c; logic [DW-1:0] d;} rsp_t;
  rsp_t q [NB][$];
  rsp_t rv_log [NB][$];
  logic [DW-1:0] mm [NB][NW];

  always #5 clk_i = ~clk_i;

  tb_mem_latency_model #(
    .NumBanks(NB), .NumWords(NW), .DataWidth(DW), .AddrWidth(AW), .ReadLatency(RL), .StallPeriod(SP)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .mem_req_i(req), .mem_gnt_o(gnt), .mem_addr_i(addr),
    .mem_wdata_i(wdata), .mem_strb_i(strb), .mem_we_i(we), .mem_rvalid_o(rvalid), .mem_rdata_o(rdata)
  );

  function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endfunction

  function automatic bit stall_at(int c);
    return STALL_EN && SP > 1 && (c % SP == SP - 1);
  endfunction

  function automatic int widx(logic [AW-1:0] a);
    return (int'(a) / SW) % NW;
  endfunction

  // reference model: cycle numbers count from reset release, responses due at accept cycle + RL
  initial forever begin
    int w;
    rsp_t r;
    @(posedge clk_i or negedge rst_ni);
    if (!rst_ni) begin
      cyc = 0;
      for (int b = 0; b < NB; b++) begin
        q[b].delete();
        for (int i = 0; i < NW; i++) mm[b][i] = '0;
      end
    end else begin
      for (int b = 0; b < NB; b++) if (req[b] && !stall_at(cyc)) begin
        w = widx(addr[b*AW +: AW]);
        r.c = cyc + RL;
        r.d = we[b] ? '0 : mm[b][w];
        q[b].push_back(r);
        if (we[b]) for (int k = 0; k < SW; k++) if (strb[b*SW+k]) mm[b][w][k*8 +: 8] = wdata[b*DW + k*8 +: 8];
      end
      cyc++;
    end
  end

  initial forever begin
    logic ev;
    logic [DW-1:0] ed;
    @(negedge clk_i);
    for (int b = 0; b < NB; b++) begin
      chk($sformatf("gnt[%0d]", b), gnt[b], rst_ni && req[b] && !stall_at(cyc));
      while (q[b].size() > 0 && q[b][0].c < cyc) void'(q[b].pop_front());
      ev = 1'b0;
      ed = '0;
      if (q[b].size() > 0 && q[b][0].c == cyc) begin
        ev = 1'b1;
        ed = q[b][0].d;
        void'(q[b].pop_front());
      end
      chk($sformatf("rvalid[%0d]", b), rvalid[b], ev);
      chk($sformatf("rdata[%0d]", b), rdata[b*DW +: DW], ed);
    end
  end

  initial forever begin
    rsp_t r;
    @(negedge clk_i);
    for (int b = 0; b < NB; b++) if (rvalid[b]) begin
      r.c = cyc;
      r.d = rdata[b*DW +: DW];
      rv_log[b].push_back(r);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int b, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    req[b] = 1'b1;
    we[b] = w;
    addr[b*AW +: AW] = a;
    wdata[b*DW +: DW] = d;
    strb[b*SW +: SW] = s;
  endtask

  task automatic issue(input int b, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s, output int acc);
    acc = -1;
    set_req(b, w, a, d, s);
    for (int i = 0; i < 10 && acc < 0; i++) begin
      @(negedge clk_i);
      if (gnt[b]) acc = cyc;
      tick();
    end
    if (acc < 0) chk("grant wait", 0, 1);
  endtask

  task automatic xfer(input int b, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s, output logic [DW-1:0] rd, output int lat);
    int acc;
    issue(b, w, a, d, s, acc);
    req[b] = 1'b0;
    rd = '0;
    lat = -1;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      @(negedge clk_i);
      if (rvalid[b]) begin
        rd = rdata[b*DW +: DW];
        lat = cyc - acc;
      end
    end
    tick();
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic [AW-1:0] a;
    logic gtr [12];
    int lat, acc, ng;
    int accs [4];
    rst_ni = 1'b0;
    repeat (3) tick();
    rst_ni = 1'b1;
    xfer(0, 1, 12'h008, 64'h1122334455667788, 8'hFF, rd, lat);
    chk("t1 write rdata", rd, 0);
    chk("t1 write latency", lat, RL);
    xfer(0, 0, 12'h008, '0, '0, rd, lat);
    chk("t1 read rdata", rd, 64'h1122334455667788);
    chk("t1 read latency", lat, RL);
    xfer(0, 1, 12'h008, '1, 8'h0F, rd, lat);
    xfer(0, 0, 12'h00C, '0, '0, rd, lat);
    chk("t2 strobe merge", rd, 64'h11223344FFFFFFFF);
    xfer(1, 1, 12'h800, 64'hA5, 8'hFF, rd, lat);
    xfer(1, 0, 12'h000, '0, '0, rd, lat);
    chk("t5 wrap read", rd, 64'hA5);
    xfer(0, 0, 12'h800, '0, '0, rd, lat);
    chk("t5 bank isolation", rd, 0);
    for (int i = 0; i < 4; i++) xfer(0, 1, AW'(i * 8), 64'hC0DE_0000_0000_0000 | 64'(i), 8'hFF, rd, lat);
    rv_log[0].delete();
    for (int i = 0; i < 4; i++) issue(0, 0, AW'(i * 8), '0, '0, accs[i]);
    req[0] = 1'b0;
    repeat (RL + 3) tick();
    chk("t3 response count", rv_log[0].size(), 4);
    for (int i = 0; i < 4; i++) if (i < rv_log[0].size()) begin
      chk($sformatf("t3 data %0d", i), rv_log[0][i].d, 64'hC0DE_0000_0000_0000 | 64'(i));
      chk($sformatf("t3 latency %0d", i), rv_log[0][i].c - accs[i], RL);
    end
    rst_ni = 1'b0;
    repeat (2) tick();
    rv_log[0].delete();
    set_req(0, 0, '0, '0, '0);
    rst_ni = 1'b1;
    ng = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      gtr[i] = gnt[0];
      ng += int'(gnt[0]);
      tick();
    end
    req[0] = 1'b0;
    repeat (RL + 2) tick();
    chk("t4 accepts", ng, STALL_EN ? 9 : 12);
    chk("t4 rvalid pulses", rv_log[0].size(), STALL_EN ? 9 : 12);
    chk("t4 gnt cycle 2", gtr[2], 1);
    chk("t4 gnt cycle 3", gtr[3], !STALL_EN);
    chk("t4 gnt cycle 7", gtr[7], !STALL_EN);
    chk("t4 gnt cycle 11", gtr[11], !STALL_EN);
    xfer(0, 1, 12'h000, 64'h55, 8'hFF, rd, lat);
    rv_log[0].delete();
    issue(0, 0, 12'h000, '0, '0, acc);
    req[0] = 1'b0;
    tick();
    rst_ni = 1'b0;
    set_req(0, 0, '0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("t6 gnt in reset", gnt[0], 0);
      tick();
    end
    req[0] = 1'b0;
    rst_ni = 1'b1;
    repeat (6) tick();
    chk("t6 dropped response", rv_log[0].size(), 0);
    xfer(0, 0, 12'h000, '0, '0, rd, lat);
    chk("t6 cleared memory", rd, 0);
    chk("t6 latency", lat, RL);
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < NB; b++) begin
        a = {1'($urandom), 5'b0, 3'($urandom), 3'($urandom)};
        set_req(b, 1'($urandom), a, {$urandom, $urandom}, 8'($urandom));
        req[b] = $urandom_range(0, 3) != 0;
      end
      if ($urandom_range(0, 499) == 0) begin
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
      end
      tick();
    end
    req = '0;
    repeat (RL + 2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
